// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline flow controller: branch funct3 codes,
// FSM state encoding and the default performance-counter width.
package pipe_ctrl_pkg;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from funct3 and the ALU flags of rs1-rs2.
module branch_cond
  import pipe_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       pos,
  output logic       cond
);

  // Map funct3 to its comparison; unsupported encodings are never taken.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = ~pos & ~zero;
      F3_BGE:  cond = pos | zero;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Control-flow and hazard sequencer: branch/jump redirect in EX, load-use
// stall between ID and EX, post-redirect squash window and saturating counters.
module pipeline_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_zero,
  input  logic             ex_pos,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [2:0] SQ_INIT = 3'(REDIRECT_CYCLES - 1);

  state_t     state_r, next_state_s;
  logic [2:0] sq_cnt_r, sq_next_s;
  logic       cond_s, taken_raw_s, load_use_s, stall_s, run_s;
  logic [CNT_W-1:0] branch_cnt_r, taken_cnt_r, stall_cnt_r, squash_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  branch_cond u_branch_cond (
    .funct3 (ex_funct3),
    .zero   (ex_zero),
    .pos    (ex_pos),
    .cond   (cond_s)
  );

  assign run_s       = (state_r == RUN);
  assign taken_raw_s = ex_jump | (ex_branch & cond_s);
  assign load_use_s  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Mealy control outputs and next-state; redirect has priority over the stall.
  always_comb begin
    next_state_s = state_r;
    sq_next_s    = sq_cnt_r;
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    taken        = 1'b0;
    stall_s      = 1'b0;
    if (reset) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      next_state_s = RUN;
      sq_next_s    = 3'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (taken_raw_s) begin
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            taken      = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
              next_state_s = SQUASH;
              sq_next_s    = SQ_INIT;
            end else begin
              next_state_s = RUN;
            end
          end else if (load_use_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_s    = 1'b1;
          end else begin
            next_state_s = RUN;
          end
        end
        SQUASH: begin
          // ID/EX hold bubbles here, so hazards and redirects are ignored.
          ifid_flush = 1'b1;
          sq_next_s  = sq_cnt_r - 3'd1;
          if (sq_cnt_r == 3'd1) begin
            next_state_s = RUN;
          end else begin
            next_state_s = SQUASH;
          end
        end
        default: begin
          next_state_s = RUN;
          sq_next_s    = 3'd0;
        end
      endcase
    end
  end

  // FSM state and squash-window counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= RUN;
      sq_cnt_r <= 3'd0;
    end else begin
      state_r  <= next_state_s;
      sq_cnt_r <= sq_next_s;
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      branch_cnt_r <= {CNT_W{1'b0}};
      taken_cnt_r  <= {CNT_W{1'b0}};
      stall_cnt_r  <= {CNT_W{1'b0}};
      squash_cnt_r <= {CNT_W{1'b0}};
    end else begin
      branch_cnt_r <= sat_inc(branch_cnt_r, run_s & (ex_branch | ex_jump));
      taken_cnt_r  <= sat_inc(taken_cnt_r, taken);
      stall_cnt_r  <= sat_inc(stall_cnt_r, stall_s);
      squash_cnt_r <= sat_inc(squash_cnt_r, ifid_flush);
    end
  end

  assign branch_cnt = branch_cnt_r;
  assign taken_cnt  = taken_cnt_r;
  assign stall_cnt  = stall_cnt_r;
  assign squash_cnt = squash_cnt_r;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Self-checking bench for pipeline_flow_ctrl: table-driven RUN vectors on a
// 1-cycle-redirect instance plus directed squash/reset/saturation sequences.
module tb_pipeline_flow_ctrl;

  // {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, taken}
  localparam logic [5:0] O_NORM  = 6'b101000;
  localparam logic [5:0] O_TAKEN = 6'b111111;
  localparam logic [5:0] O_STALL = 6'b000010;
  localparam logic [5:0] O_SQ    = 6'b101100;
  localparam logic [5:0] O_RST   = 6'b101110;

  typedef struct {
    logic       br;
    logic       jmp;
    logic [2:0] f3;
    logic       zero;
    logic       pos;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch, ex_jump;
  logic [2:0] ex_funct3;
  logic ex_zero, ex_pos, cnt_clr;

  logic pw1, ps1, iw1, if1, xf1, tk1;
  logic [15:0] bc1, tc1, sc1, qc1;
  logic pw3, ps3, iw3, if3, xf3, tk3;
  logic [3:0] bc3, tc3, sc3, qc3;

  logic [5:0] o1, o3;
  assign o1 = {pw1, ps1, iw1, if1, xf1, tk1};
  assign o3 = {pw3, ps3, iw3, if3, xf3, tk3};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_flow_ctrl #(.REDIRECT_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(rst1), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_pos(ex_pos), .cnt_clr(cnt_clr),
    .pc_write(pw1), .pc_sel(ps1), .ifid_write(iw1), .ifid_flush(if1),
    .idex_flush(xf1), .taken(tk1), .branch_cnt(bc1), .taken_cnt(tc1),
    .stall_cnt(sc1), .squash_cnt(qc1)
  );

  pipeline_flow_ctrl #(.REDIRECT_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(rst3), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_pos(ex_pos), .cnt_clr(cnt_clr),
    .pc_write(pw3), .pc_sel(ps3), .ifid_write(iw3), .ifid_flush(if3),
    .idex_flush(xf3), .taken(tk3), .branch_cnt(bc3), .taken_cnt(tc3),
    .stall_cnt(sc3), .squash_cnt(qc3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ex_branch   = v.br;
    ex_jump     = v.jmp;
    ex_funct3   = v.f3;
    ex_zero     = v.zero;
    ex_pos      = v.pos;
    ex_mem_read = v.ld;
    ex_rd       = v.rd;
    id_rs1      = v.rs1;
    id_rs2      = v.rs2;
    id_uses_rs1 = v.u1;
    id_uses_rs2 = v.u2;
  endtask

  function automatic vec_t mk(input logic br, input logic jmp, input logic [2:0] f3,
                              input logic zero, input logic pos, input logic ld,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [5:0] exp);
    vec_t v;
    v.br = br; v.jmp = jmp; v.f3 = f3; v.zero = zero; v.pos = pos; v.ld = ld;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exp = exp;
    return v;
  endfunction

  vec_t idle;
  vec_t loaduse5;
  vec_t vecs[$];

  initial begin
    int exp_b, exp_t, exp_s, exp_q;
    idle     = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM);
    loaduse5 = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, O_STALL);

    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN)); // beq z
    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM));  // beq nz
    vecs.push_back(mk(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN)); // bne
    vecs.push_back(mk(1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM));
    vecs.push_back(mk(1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN)); // blt neg
    vecs.push_back(mk(1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM));
    vecs.push_back(mk(1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM));
    vecs.push_back(mk(1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN)); // bge pos
    vecs.push_back(mk(1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN)); // bge eq
    vecs.push_back(mk(1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM));
    vecs.push_back(mk(1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NORM));  // bad f3
    vecs.push_back(mk(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN)); // jal
    vecs.push_back(mk(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN)); // both
    vecs.push_back(loaduse5);
    vecs.push_back(mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, O_NORM));  // rd=x0
    vecs.push_back(mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, O_NORM));  // unused rs1
    vecs.push_back(mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, O_STALL)); // rs1 hit
    vecs.push_back(mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, O_NORM));  // no load
    vecs.push_back(mk(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, O_TAKEN)); // bne+lu

    cnt_clr = 1'b0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    drive(idle);
    #1;
    chk("reset_outputs", 32'(o1), 32'(O_RST));
    tick();
    chk("reset_outputs_hold", 32'(o1), 32'(O_RST));
    chk("reset_cnt", 32'({bc1, tc1, sc1, qc1}), 32'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("idle_after_reset", 32'(o1), 32'(O_NORM));

    // Table of RUN-state vectors on the 1-cycle-redirect instance.
    exp_b = 0; exp_t = 0; exp_s = 0; exp_q = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(o1), 32'(vecs[i].exp));
      if (vecs[i].br || vecs[i].jmp) exp_b++;
      if (vecs[i].exp == O_TAKEN) begin
        exp_t++;
        exp_q++;
      end
      if (vecs[i].exp == O_STALL) exp_s++;
      tick();
    end
    drive(idle);
    #1;
    chk("tbl_idle_outs", 32'(o1), 32'(O_NORM));
    chk("tbl_branch_cnt", 32'(bc1), 32'(exp_b));
    chk("tbl_taken_cnt", 32'(tc1), 32'(exp_t));
    chk("tbl_stall_cnt", 32'(sc1), 32'(exp_s));
    chk("tbl_squash_cnt", 32'(qc1), 32'(exp_q));

    // Three-cycle squash window: load-use during the window must not stall.
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    drive(mk(1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN));
    #1;
    chk("sq_c1_outs", 32'(o3), 32'(O_TAKEN));
    tick();
    drive(loaduse5);
    ex_jump = 1'b1;
    #1;
    chk("sq_c2_outs", 32'(o3), 32'(O_SQ));
    tick();
    #1;
    chk("sq_c3_outs", 32'(o3), 32'(O_SQ));
    tick();
    ex_jump = 1'b0;
    #1;
    chk("sq_c4_stall", 32'(o3), 32'(O_STALL));
    chk("sq_squash_cnt", 32'(qc3), 32'd3);
    chk("sq_branch_cnt", 32'(bc3), 32'd1);
    chk("sq_taken_cnt", 32'(tc3), 32'd1);
    chk("sq_stall_cnt", 32'(sc3), 32'd0);
    tick();
    drive(idle);
    #1;
    chk("sq_stall_one_cycle", 32'(o3), 32'(O_NORM));
    chk("sq_stall_cnt_after", 32'(sc3), 32'd1);

    // Reset in the second squash cycle, then a normal beq redirect.
    drive(mk(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN));
    tick();
    drive(idle);
    rst3 = 1'b1;
    #1;
    chk("midsq_reset_outs", 32'(o3), 32'(O_RST));
    tick();
    chk("midsq_reset_cnt", 32'({bc3, tc3, sc3, qc3}), 32'd0);
    rst3 = 1'b0;
    #1;
    chk("midsq_run_outs", 32'(o3), 32'(O_NORM));
    drive(mk(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN));
    #1;
    chk("midsq_beq_outs", 32'(o3), 32'(O_TAKEN));
    tick();
    drive(idle);
    #1;
    chk("midsq_beq_sq", 32'(o3), 32'(O_SQ));
    chk("midsq_taken_cnt", 32'(tc3), 32'd1);
    tick();
    tick();

    // Saturation on the 4-bit counters, then clear coincident with a taken bne.
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    drive(loaduse5);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_stall_15", 32'(sc3), 32'd15);
    #1;
    chk("sat_still_stalling", 32'(o3), 32'(O_STALL));
    tick();
    chk("sat_stall_hold", 32'(sc3), 32'd15);
    drive(mk(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_TAKEN));
    cnt_clr = 1'b1;
    #1;
    chk("clr_taken_outs", 32'(o3), 32'(O_TAKEN));
    tick();
    cnt_clr = 1'b0;
    drive(idle);
    chk("clr_all_cnt", 32'({bc3, tc3, sc3, qc3}), 32'd0);
    tick();
    chk("clr_then_squash_cnt", 32'(qc3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
